// File: rtl/mod_inverse_pkg.sv
// mod_inverse_pkg: shared defaults, state encodings and loop bound for mod_inverse.
package mod_inverse_pkg;
   localparam int DEF_WIDTH = 32;
   localparam logic [31:0] DEF_MOD = 32'd998244353;
   localparam logic [31:0] DEF_R2MOD = 32'd932051910;
   localparam logic [31:0] DEF_NPRIME = 32'd998244351;
   localparam int LOOP_BOUND = 4 * DEF_WIDTH;
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_REDUCE = 3'd1;
   localparam logic [2:0] S_LOOP = 3'd2;
   localparam logic [2:0] S_CONV = 3'd3;
   localparam logic [2:0] S_FINISH = 3'd4;
   typedef enum logic [2:0] {
      IDLE = S_IDLE,
      REDUCE = S_REDUCE,
      LOOP = S_LOOP,
      CONV = S_CONV,
      FINISH = S_FINISH
   } state_t;
endpackage

// File: rtl/mod_inverse_half_sub.sv
// mod_half_sub: combinational modular halving of x, or (x-y) mod MOD, for x,y in [0, MOD-1].
module mod_half_sub #(
   parameter int WIDTH = 32,
   parameter logic [WIDTH-1:0] MOD = WIDTH'(998244353)
) (
   input  logic [WIDTH-1:0] i_x,
   input  logic [WIDTH-1:0] i_y,
   input  logic             i_half,
   output logic [WIDTH-1:0] o_z
);
   logic [WIDTH:0] w_xm;
   logic [WIDTH-1:0] w_half, w_sub;
   // x+MOD needs the extra bit only for the halving path
   assign w_xm = {1'b0, i_x} + {1'b0, MOD};
   assign w_half = i_x[0] ? w_xm[WIDTH:1] : (i_x >> 1);
   assign w_sub = (i_x >= i_y) ? i_x - i_y : w_xm[WIDTH-1:0] - i_y;
   assign o_z = i_half ? w_half : w_sub;
endmodule

// File: rtl/mod_inverse.sv
// mod_inverse: a^-1 mod MOD by binary extended Euclid, one step per cycle.
// Define MODINV_MONT_OUT_EN to add a CONV state that returns the result in Montgomery form.
module mod_inverse
   import mod_inverse_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter logic [WIDTH-1:0] MOD = WIDTH'(DEF_MOD)
`ifdef MODINV_MONT_OUT_EN
   , parameter logic [WIDTH-1:0] R2MOD = WIDTH'(DEF_R2MOD),
   parameter logic [WIDTH-1:0] NPRIME = WIDTH'(DEF_NPRIME)
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] result
);
   state_t r_state;
   logic [WIDTH-1:0] r_u, r_v, r_x1, r_x2;
   logic [WIDTH-1:0] w_x1n, w_x2n;
   logic w_u_one, w_v_one;

   assign w_u_one = (r_u == WIDTH'(1));
   assign w_v_one = (r_v == WIDTH'(1));

   mod_half_sub #(.WIDTH(WIDTH), .MOD(MOD)) u_x1 (
      .i_x(r_x1), .i_y(r_x2), .i_half(~r_u[0]), .o_z(w_x1n)
   );
   mod_half_sub #(.WIDTH(WIDTH), .MOD(MOD)) u_x2 (
      .i_x(r_x2), .i_y(r_x1), .i_half(~r_v[0]), .o_z(w_x2n)
   );

`ifdef MODINV_MONT_OUT_EN
   logic [WIDTH-1:0] w_mont;
   mont_redc #(.WIDTH(WIDTH), .MOD(MOD), .NPRIME(NPRIME)) u_redc (
      .a(r_x1), .b(R2MOD), .result(w_mont)
   );
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_u <= '0;
         r_v <= '0;
         r_x1 <= '0;
         r_x2 <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         err <= 1'b0;
         result <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  r_u <= a;
                  r_v <= MOD;
                  r_x1 <= WIDTH'(1);
                  r_x2 <= '0;
                  err <= 1'b0;
                  busy <= 1'b1;
                  r_state <= REDUCE;
               end
            end
            REDUCE: begin
               if (r_u >= MOD) r_u <= r_u - MOD;
               else if (r_u == '0) begin
                  err <= 1'b1;
                  result <= '0;
                  done <= 1'b1;
                  busy <= 1'b0;
                  r_state <= FINISH;
               end else r_state <= LOOP;
            end
            LOOP: begin
               if (w_u_one || w_v_one) begin
`ifdef MODINV_MONT_OUT_EN
                  r_x1 <= w_u_one ? r_x1 : r_x2;
                  r_state <= CONV;
`else
                  result <= w_u_one ? r_x1 : r_x2;
                  done <= 1'b1;
                  busy <= 1'b0;
                  r_state <= FINISH;
`endif
               end else if (!r_u[0]) begin
                  r_u <= r_u >> 1;
                  r_x1 <= w_x1n;
               end else if (!r_v[0]) begin
                  r_v <= r_v >> 1;
                  r_x2 <= w_x2n;
               end else if (r_u >= r_v) begin
                  r_u <= r_u - r_v;
                  r_x1 <= w_x1n;
               end else begin
                  r_v <= r_v - r_u;
                  r_x2 <= w_x2n;
               end
            end
`ifdef MODINV_MONT_OUT_EN
            CONV: begin
               result <= w_mont;
               done <= 1'b1;
               busy <= 1'b0;
               r_state <= FINISH;
            end
`endif
            FINISH: begin
               if (!start) begin
                  done <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
